// File: rtl/axi4_lite_regfile_gen_pkg.sv
// Shared types and helpers for the parametrised AXI4-Lite register file.
package axi4_lite_regfile_gen_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Access behaviour of a single register
  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_W1C = 2'd2
  } reg_access_e;

  typedef enum logic [2:0] {
    WR_IDLE   = 3'd0,
    WR_GOT_AW = 3'd1,
    WR_GOT_W  = 3'd2,
    WR_COMMIT = 3'd3,
    WR_RESP   = 3'd4
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  // Resolve a register's access type: the IRQ enable register is always RW,
  // otherwise RO wins over W1C.
  function automatic reg_access_e reg_access(input logic ro, input logic w1c,
                                             input logic irq_en);
    reg_access_e acc;
    acc = ACC_RW;
    if (irq_en) begin
      acc = ACC_RW;
    end else if (ro) begin
      acc = ACC_RO;
    end else if (w1c) begin
      acc = ACC_W1C;
    end
    return acc;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_cell.sv
// One register of the register file: RW byte-strobed, RO hardware-driven,
// or W1C with hardware set (set wins over a same-cycle clear).
module axi4_lite_reg_cell
  import axi4_lite_regfile_gen_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter reg_access_e           ACCESS     = ACC_RW,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   hw_val,
  input  logic [DATA_WIDTH-1:0]   hw_set,
  output logic [DATA_WIDTH-1:0]   q
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] RST_Q = (ACCESS == ACC_RW) ? RST_VAL : '0;

  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] d_next;

  // Expand byte strobes to a bit mask
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      bit_mask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  // Next value according to the access type
  always_comb begin
    d_next = q;
    case (ACCESS)
      ACC_RO:  d_next = hw_val;
      ACC_W1C: d_next = (we ? (q & ~(wdata & bit_mask)) : q) | hw_set;
      default: d_next = we ? ((q & ~bit_mask) | (wdata & bit_mask)) : q;
    endcase
  end

  // Register storage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q <= RST_Q;
    end else begin
      q <= d_next;
    end
  end

endmodule

// File: rtl/axi4_lite_regfile_gen.sv
// Parametrised AXI4-Lite register file with RW / RO / W1C registers and a
// level IRQ from W1C registers gated by the last (enable) register.
// Optional build macro: AXI4L_REGFILE_RO_ERR_EN -- AXI writes to RO
// registers answer SLVERR instead of being silently dropped with OKAY.
module axi4_lite_regfile_gen
  import axi4_lite_regfile_gen_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]   W1C_MASK   = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  // write response channel
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  // hardware side
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_val,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_w1c_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic                           irq
);

  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned ADDR_LSB   = $clog2(STRB_W);
  localparam int unsigned IRQ_EN_IDX = NUM_REGS - 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_W);
  localparam logic [IDX_W-1:0]      IRQ_EN_SEL = IDX_W'(IRQ_EN_IDX);

`ifdef AXI4L_REGFILE_RO_ERR_EN
  localparam bit RO_ERR_EN = 1'b1;
`else
  localparam bit RO_ERR_EN = 1'b0;
`endif

  wr_state_e wr_state;
  rd_state_e rd_state;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  commit_q;

  logic aw_fire_c;
  logic w_fire_c;
  logic b_fire_c;
  logic ar_fire_c;
  logic r_fire_c;

  logic [IDX_W-1:0]    aw_idx_c;
  logic [IDX_W-1:0]    ar_idx_c;
  logic                aw_in_range_c;
  logic                ar_in_range_c;
  logic [NUM_REGS-1:0] ro_vec;
  logic [NUM_REGS-1:0] w1c_vec;
  logic [NUM_REGS-1:0] cell_we_c;
  logic                irq_c;

  logic [DATA_WIDTH-1:0] q_arr [NUM_REGS];

  assign aw_fire_c = awvalid && awready;
  assign w_fire_c  = wvalid && wready;
  assign b_fire_c  = bvalid && bready;
  assign ar_fire_c = arvalid && arready;
  assign r_fire_c  = rvalid && rready;

  assign aw_idx_c      = aw_addr_q[ADDR_LSB +: IDX_W];
  assign ar_idx_c      = araddr[ADDR_LSB +: IDX_W];
  assign aw_in_range_c = aw_addr_q < ADDR_LIMIT;
  assign ar_in_range_c = araddr < ADDR_LIMIT;

  // Register cells, one per address
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    localparam reg_access_e ACC = reg_access(RO_MASK[i], W1C_MASK[i], i == IRQ_EN_IDX);

    assign ro_vec[i]    = (ACC == ACC_RO);
    assign w1c_vec[i]   = (ACC == ACC_W1C);
    assign cell_we_c[i] = commit_q && aw_in_range_c && (aw_idx_c == IDX_W'(i));

    axi4_lite_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACCESS     (ACC),
      .RST_VAL    (RST_VAL)
    ) u_cell (
      .aclk    (aclk),
      .aresetn (aresetn),
      .we      (cell_we_c[i]),
      .wdata   (w_data_q),
      .wstrb   (w_strb_q),
      .hw_val  (hw_ro_val[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set  (hw_w1c_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .q       (q_arr[i])
    );

    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q_arr[i];
  end

  // Write path: collect AW and W in any order, commit, then respond.
  // The commit strobe is registered so the cell update, wr_pulse and bvalid
  // all become visible on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state  <= WR_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      commit_q  <= 1'b0;
      wr_pulse  <= '0;
    end else begin
      commit_q <= 1'b0;
      wr_pulse <= cell_we_c & ~ro_vec;
      case (wr_state)
        WR_IDLE: begin
          if (aw_fire_c && w_fire_c) begin
            aw_addr_q <= awaddr;
            w_data_q  <= wdata;
            w_strb_q  <= wstrb;
            awready   <= 1'b0;
            wready    <= 1'b0;
            wr_state  <= WR_COMMIT;
          end else if (aw_fire_c) begin
            aw_addr_q <= awaddr;
            awready   <= 1'b0;
            wready    <= 1'b1;
            wr_state  <= WR_GOT_AW;
          end else if (w_fire_c) begin
            w_data_q  <= wdata;
            w_strb_q  <= wstrb;
            awready   <= 1'b1;
            wready    <= 1'b0;
            wr_state  <= WR_GOT_W;
          end else begin
            awready   <= 1'b1;
            wready    <= 1'b1;
          end
        end
        WR_GOT_AW: begin
          if (w_fire_c) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            wready   <= 1'b0;
            wr_state <= WR_COMMIT;
          end
        end
        WR_GOT_W: begin
          if (aw_fire_c) begin
            aw_addr_q <= awaddr;
            awready   <= 1'b0;
            wr_state  <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          commit_q <= 1'b1;
          if (!aw_in_range_c || (RO_ERR_EN && ro_vec[aw_idx_c])) begin
            bresp <= RESP_SLVERR;
          end else begin
            bresp <= RESP_OKAY;
          end
          wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (commit_q) begin
            bvalid <= 1'b1;
          end else if (b_fire_c) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: begin
          awready  <= 1'b0;
          wready   <= 1'b0;
          bvalid   <= 1'b0;
          wr_state <= WR_IDLE;
        end
      endcase
    end
  end

  // Read path: capture the addressed register at the AR handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_fire_c) begin
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= ar_in_range_c ? q_arr[ar_idx_c] : '0;
            rresp    <= ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
            rd_state <= RD_RESP;
          end else begin
            arready  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (r_fire_c) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: begin
          arready  <= 1'b0;
          rvalid   <= 1'b0;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  // Any enabled pending W1C bit raises the interrupt
  always_comb begin
    irq_c = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w1c_vec[i]) begin
        irq_c = irq_c | (|(q_arr[i] & q_arr[IRQ_EN_SEL]));
      end
    end
  end

  // Registered interrupt output
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_c;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_gen.sv
// Directed bench for axi4_lite_regfile_gen: 16 x 32-bit registers,
// regs 4,5 RO (5 also in W1C mask), regs 0,1 W1C, reg 15 IRQ enable.
module tb_axi4_lite_regfile_gen;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 32;

`ifdef AXI4L_REGFILE_RO_ERR_EN
  localparam logic [1:0] RO_RESP = 2'b10;
`else
  localparam logic [1:0] RO_RESP = 2'b00;
`endif

  logic              clk;
  logic              aresetn;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  hw_ro_val;
  logic [NR*DW-1:0]  hw_w1c_set;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     wr_pulse;
  logic              irq;

  int tests = 0;
  int fails = 0;

  axi4_lite_regfile_gen #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (16'h0030),
    .W1C_MASK   (16'h8023),
    .RST_VAL    (32'hFFFF_FFFF)
  ) dut (
    .aclk       (clk),
    .aresetn    (aresetn),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .hw_ro_val  (hw_ro_val),
    .hw_w1c_set (hw_w1c_set),
    .reg_q      (reg_q),
    .wr_pulse   (wr_pulse),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_pulse;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  function automatic logic [31:0] regw(input int i);
    return reg_q[i*DW +: DW];
  endfunction

  function automatic logic [31:0] exp_rst(input int i);
    return (i == 0 || i == 1 || i == 4 || i == 5) ? 32'h0 : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] exp_after_table(input int i);
    case (i)
      0, 1:    return 32'h0;
      2:       return 32'hA5A5_A5A5;
      4:       return 32'hC0DE_0004;
      5:       return 32'hC0DE_0005;
      6:       return 32'hAABB_FF11;
      15:      return 32'h0000_0008;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check_rst(input string tag);
    check({tag, "_ctrl"}, {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check({tag, "_resp"}, {bresp, rresp}, 4'b0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_pulse_irq"}, {wr_pulse, irq}, 17'b0);
    for (int i = 0; i < NR; i++) check($sformatf("%s_reg%0d", tag, i), regw(i), exp_rst(i));
  endtask

  task automatic wait_b(output logic [1:0] resp, output int lat, output logic [15:0] pulses);
    int k;
    k = 0;
    pulses = '0;
    lat = -1;
    resp = 2'b11;
    while (k < 50) begin
      @(negedge clk);
      k++;
      pulses |= wr_pulse;
      if (bvalid) break;
    end
    if (!bvalid) begin
      timeout("bvalid");
      return;
    end
    lat = k - 1;
    resp = bresp;
    bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat, output logic [15:0] pulses);
    int n;
    resp = 2'b11;
    lat = -1;
    pulses = '0;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(awready && wready)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout("aw_w_ready");
      return;
    end
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    wait_b(resp, lat, pulses);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = '1;
    resp = 2'b11;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      arvalid = 1'b0;
      timeout("arready");
      return;
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      timeout("rvalid");
      return;
    end
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic [15:0] pulses;
    int          lat;
    int          bad;
    int          n;

    //                wr    addr          data          strb  resp         rdata         pulse
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'hF, 2'b00,   32'h0,         16'h0004};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00,   32'hA5A5_A5A5, 16'h0};
    vecs[2]  = '{1'b1, 32'h0000_0018, 32'hAABB_CCDD, 4'hC, 2'b00,   32'h0,         16'h0040};
    vecs[3]  = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 2'b00,   32'hAABB_FFFF, 16'h0};
    vecs[4]  = '{1'b1, 32'h0000_001A, 32'h0000_0011, 4'h1, 2'b00,   32'h0,         16'h0040};
    vecs[5]  = '{1'b0, 32'h0000_001B, 32'h0,         4'h0, 2'b00,   32'hAABB_FF11, 16'h0};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'h0,         4'hF, RO_RESP, 32'h0,         16'h0};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00,   32'hC0DE_0004, 16'h0};
    vecs[8]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 2'b00,   32'hC0DE_0005, 16'h0};
    vecs[9]  = '{1'b1, 32'h0000_0014, 32'h0,         4'hF, RO_RESP, 32'h0,         16'h0};
    vecs[10] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10,   32'h0,         16'h0};
    vecs[11] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 2'b10,   32'h0,         16'h0};
    vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10,   32'h0,         16'h0};
    vecs[13] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00,   32'hFFFF_FFFF, 16'h0};
    vecs[14] = '{1'b1, 32'h0000_003C, 32'h0000_0008, 4'hF, 2'b00,   32'h0,         16'h8000};
    vecs[15] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00,   32'h0000_0008, 16'h0};
    vecs[16] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00,   32'h0,         16'h0};
    vecs[17] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00,   32'hFFFF_FFFF, 16'h0};

    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    hw_w1c_set = '0;
    for (int i = 0; i < NR; i++) hw_ro_val[i*DW +: DW] = {16'hC0DE, 16'(i)};

    // Reset state
    repeat (3) @(negedge clk);
    check_rst("rst0");
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", {awready, wready, arready}, 3'b111);
    check("irq_after_rst", irq, 1'b0);

    // Table-driven single transactions
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].wr) begin
        axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, lat, pulses);
        check($sformatf("v%0d_bresp", v), resp, vecs[v].exp_resp);
        check($sformatf("v%0d_blat", v), 32'(lat), 32'd2);
        check($sformatf("v%0d_pulse", v), pulses, vecs[v].exp_pulse);
      end else begin
        axi_read(vecs[v].addr, data, resp);
        check($sformatf("v%0d_rresp", v), resp, vecs[v].exp_resp);
        check($sformatf("v%0d_rdata", v), data, vecs[v].exp_rdata);
      end
    end
    for (int i = 0; i < NR; i++) check($sformatf("table_reg%0d", i), regw(i), exp_after_table(i));

    // W arrives 3 cycles before AW, partial strobe on reg3
    @(negedge clk);
    wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wready) timeout("w_first_wready");
    @(posedge clk);
    #1 wvalid = 1'b0;
    @(negedge clk);
    check("got_w_readys", {awready, wready}, 2'b10);
    repeat (2) @(negedge clk);
    awaddr = 32'h0000_000C; awvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0;
    wait_b(resp, lat, pulses);
    check("wfirst_bresp", resp, 2'b00);
    check("wfirst_blat", 32'(lat), 32'd2);
    check("wfirst_pulse", pulses, 16'h0008);
    check("wfirst_reg3", regw(3), 32'hFFFF_5678);

    // W1C: hardware set, clear with concurrent set, irq gating
    @(negedge clk);
    hw_w1c_set[0*DW +: DW] = 32'hF;
    hw_w1c_set[5*DW +: DW] = 32'hFFFF_FFFF;
    @(negedge clk);
    hw_w1c_set = '0;
    check("w1c_set_reg0", regw(0), 32'h0000_000F);
    check("ro_ignores_set_reg5", regw(5), 32'hC0DE_0005);
    @(negedge clk);
    check("irq_on_set", irq, 1'b1);
    hw_w1c_set[0*DW +: DW] = 32'h1;
    axi_write(32'h0, 32'h5, 4'hF, resp, lat, pulses);
    hw_w1c_set = '0;
    check("w1c_bresp", resp, 2'b00);
    check("w1c_pulse", pulses, 16'h0001);
    check("w1c_reg0", regw(0), 32'h0000_000B);
    check("irq_still_on", irq, 1'b1);
    axi_write(32'h3C, 32'h4, 4'hF, resp, lat, pulses);
    repeat (2) @(negedge clk);
    check("irq_masked", irq, 1'b0);
    check("w1c_reg0_kept", regw(0), 32'h0000_000B);

    // bready held low: response stable, no new AW accepted, reads proceed
    @(negedge clk);
    awaddr = 32'h1C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) timeout("hold_bvalid");
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (!bvalid || bresp !== 2'b00 || awready !== 1'b0) bad++;
    end
    check("b_hold_bad_cycles", 32'(bad), 32'd0);
    axi_read(32'h1C, data, resp);
    check("read_during_b_hold", data, 32'h77);
    check("b_still_valid", bvalid, 1'b1);
    @(negedge clk);
    bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
    @(negedge clk);
    check("b_released", bvalid, 1'b0);

    // Reset in the middle of a write
    @(negedge clk);
    awaddr = 32'h08; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    check_rst("rst1");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst1", {awready, wready, arready, bvalid}, 4'b1110);
    axi_read(32'h08, data, resp);
    check("reg2_after_rst1", data, 32'hFFFF_FFFF);
    axi_read(32'h00, data, resp);
    check("reg0_after_rst1", data, 32'h0);
    axi_read(32'h10, data, resp);
    check("reg4_after_rst1", data, 32'hC0DE_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
